// File: rtl/if_pc_unit_if.sv
// Fetch-side bundle for if_pc_unit: redirect/stall controls, instruction-memory
// handshake and the decode-facing PC/valid outputs.
interface if_pc_unit_if #(
  parameter int unsigned N = 32
);
  logic         stall;
  logic         branch_taken;
  logic [N-1:0] branch_target;
  logic         mem_ready;
  logic         mem_req;
  logic [N-1:0] mem_addr;
  logic [N-1:0] pc_out;
  logic [N-1:0] pc_plus4;
  logic         if_valid;
  logic         misaligned;

  // Driver side: pipeline control and memory response.
  modport master (
    output stall, branch_taken, branch_target, mem_ready,
    input  mem_req, mem_addr, pc_out, pc_plus4, if_valid, misaligned
  );

  // Fetch unit side.
  modport slave (
    input  stall, branch_taken, branch_target, mem_ready,
    output mem_req, mem_addr, pc_out, pc_plus4, if_valid, misaligned
  );
endinterface

// File: rtl/if_pc_unit.sv
// Instruction-fetch PC unit: sequential fetch at one instruction per cycle,
// stall hold, aligned redirects and a sticky halt on misaligned redirects.
module if_pc_unit #(
  parameter int unsigned   N        = 32,
  parameter logic [N-1:0]  RESET_PC = {N{1'b0}}
) (
  input  logic        clk,
  input  logic        rst,
  if_pc_unit_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StReq, StHold, StHalt} state_e;

  state_e       state_q, state_d;
  logic [N-1:0] pc_q, pc_d;
  logic [N-1:0] pc_out_q, pc_out_d;
  logic         if_valid_q, if_valid_d;
  logic         misaligned_q, misaligned_d;
  logic [N-1:0] pc_plus4;
  logic         mem_req;

  // Carry-out is dropped so the PC wraps modulo 2^N.
  assign pc_plus4 = pc_q + N'(4);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: PC, decode-facing PC/valid and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= RESET_PC;
      pc_out_q     <= RESET_PC;
      if_valid_q   <= 1'b0;
      misaligned_q <= 1'b0;
    end else begin
      pc_q         <= pc_d;
      pc_out_q     <= pc_out_d;
      if_valid_q   <= if_valid_d;
      misaligned_q <= misaligned_d;
    end
  end

  // Next-state and Moore request decode; a redirect overrides the per-state result.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pc_out_d     = pc_out_q;
    if_valid_d   = if_valid_q;
    misaligned_d = misaligned_q;
    mem_req      = 1'b0;

    unique case (state_q)
      StIdle: begin
        state_d    = StReq;
        if_valid_d = 1'b0;
      end
      StReq: begin
        mem_req = 1'b1;
        if (bus.mem_ready) begin
          pc_out_d   = pc_q;
          if_valid_d = 1'b1;
          pc_d       = pc_plus4;
          state_d    = bus.stall ? StHold : StReq;
        end else begin
          if_valid_d = 1'b0;
        end
      end
      StHold: begin
        if (!bus.stall) begin
          state_d    = StReq;
          if_valid_d = 1'b0;
        end
      end
      StHalt: begin
        if_valid_d = 1'b0;
      end
    endcase

    // Redirects win over stall and mem_ready; a fetch landing this cycle is dropped.
    if (state_q != StHalt && bus.branch_taken) begin
      pc_out_d   = pc_out_q;
      if_valid_d = 1'b0;
      if (bus.branch_target[1:0] == 2'b00) begin
        pc_d    = bus.branch_target;
        state_d = StReq;
      end else begin
        pc_d         = pc_q;
        misaligned_d = 1'b1;
        state_d      = StHalt;
      end
    end
  end

  assign bus.mem_req    = mem_req;
  assign bus.mem_addr   = pc_q;
  assign bus.pc_out     = pc_out_q;
  assign bus.pc_plus4   = pc_plus4;
  assign bus.if_valid   = if_valid_q;
  assign bus.misaligned = misaligned_q;

endmodule

// File: tb/tb_if_pc_unit.sv
// Directed bench for if_pc_unit: reset, sequential fetch, stall hold,
// redirects, memory wait, mid-request reset, misaligned halt and PC wrap.
module tb_if_pc_unit;

  logic clk;
  logic rst;
  logic rst2;
  int   checks;
  int   errors;

  if_pc_unit_if #(.N(32)) bus ();
  if_pc_unit_if #(.N(32)) bus2 ();

  if_pc_unit #(.N(32), .RESET_PC(32'h0000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  if_pc_unit #(.N(32), .RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk (clk),
    .rst (rst2),
    .bus (bus2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling or driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.stall = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_target = 32'h0;
    bus.mem_ready = 1'b0;
    step();
    step();
    checks++;
    if (bus.if_valid !== 1'b0) begin
      errors++; $display("FAIL reset_if_valid got %0b want 0", bus.if_valid);
    end
    checks++;
    if (bus.misaligned !== 1'b0) begin
      errors++; $display("FAIL reset_misaligned got %0b want 0", bus.misaligned);
    end
    checks++;
    if (bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL reset_mem_req got %0b want 0", bus.mem_req);
    end
    checks++;
    if (bus.mem_addr !== 32'h0 || bus.pc_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_pc got addr %h pc_out %h want 0 0", bus.mem_addr, bus.pc_out);
    end
    checks++;
    if (bus.pc_plus4 !== 32'h4) begin
      errors++; $display("FAIL reset_pc_plus4 got %h want 4", bus.pc_plus4);
    end
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    // First cycle after release is IDLE: no request yet.
    checks++;
    if (bus.mem_req !== 1'b0) begin
      errors++; $display("FAIL first_cycle_mem_req got %0b want 0", bus.mem_req);
    end
    step();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL first_req got req %0b addr %h want 1 0", bus.mem_req, bus.mem_addr);
    end
  endtask

  task automatic test_sequential();
    logic [31:0] exp_addr [2];
    logic [31:0] exp_pc   [2];
    exp_addr[0] = 32'h4; exp_addr[1] = 32'h8;
    exp_pc[0]   = 32'h0; exp_pc[1]   = 32'h4;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.mem_addr !== exp_addr[i] || bus.mem_req !== 1'b1) begin
        errors++;
        $display("FAIL seq_addr[%0d] got %h req %0b want %h 1", i, bus.mem_addr, bus.mem_req,
                 exp_addr[i]);
      end
      checks++;
      if (bus.if_valid !== 1'b1 || bus.pc_out !== exp_pc[i]) begin
        errors++;
        $display("FAIL seq_pc_out[%0d] got %h valid %0b want %h 1", i, bus.pc_out,
                 bus.if_valid, exp_pc[i]);
      end
    end
  endtask

  task automatic test_stall();
    bus.stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.stall = 1'b1;
      step();
      checks++;
      if (bus.pc_out !== 32'h8 || bus.if_valid !== 1'b1 || bus.mem_req !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d] got pc_out %h valid %0b req %0b want 8 1 0", i, bus.pc_out,
                 bus.if_valid, bus.mem_req);
      end
      if (i == 2) bus.stall = 1'b0;
    end
    step();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'hC || bus.if_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release got req %0b addr %h valid %0b want 1 c 0", bus.mem_req,
               bus.mem_addr, bus.if_valid);
    end
  endtask

  task automatic test_branch();
    // Redirect in a cycle with mem_ready=1 and stall=1: fetch discarded.
    bus.stall = 1'b1;
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h100;
    step();
    bus.branch_taken = 1'b0;
    bus.stall = 1'b0;
    checks++;
    if (bus.if_valid !== 1'b0 || bus.mem_addr !== 32'h100 || bus.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL branch_req got valid %0b addr %h req %0b want 0 100 1", bus.if_valid,
               bus.mem_addr, bus.mem_req);
    end
    step();
    checks++;
    if (bus.if_valid !== 1'b1 || bus.pc_out !== 32'h100 || bus.mem_addr !== 32'h104) begin
      errors++;
      $display("FAIL branch_fetch got valid %0b pc_out %h addr %h want 1 100 104",
               bus.if_valid, bus.pc_out, bus.mem_addr);
    end
    // Redirect out of HOLD.
    bus.stall = 1'b1;
    step();
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h200;
    step();
    bus.branch_taken = 1'b0;
    bus.stall = 1'b0;
    checks++;
    if (bus.if_valid !== 1'b0 || bus.mem_addr !== 32'h200 || bus.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL branch_from_hold got valid %0b addr %h req %0b want 0 200 1",
               bus.if_valid, bus.mem_addr, bus.mem_req);
    end
  endtask

  task automatic test_mem_wait();
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++;
      if (bus.mem_addr !== 32'h200 || bus.if_valid !== 1'b0 || bus.mem_req !== 1'b1) begin
        errors++;
        $display("FAIL mem_wait[%0d] got addr %h valid %0b req %0b want 200 0 1", i,
                 bus.mem_addr, bus.if_valid, bus.mem_req);
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h40;
    step();
    bus.branch_taken = 1'b0;
    checks++;
    if (bus.mem_addr !== 32'h40 || bus.mem_req !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset got addr %h req %0b want 40 1", bus.mem_addr, bus.mem_req);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.mem_addr !== 32'h0 || bus.if_valid !== 1'b0 || bus.mem_req !== 1'b0
        || bus.pc_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_mid got addr %h valid %0b req %0b pc_out %h want 0 0 0 0",
               bus.mem_addr, bus.if_valid, bus.mem_req, bus.pc_out);
    end
  endtask

  task automatic test_misaligned();
    bus.mem_ready = 1'b1;
    step();
    step();
    checks++;
    if (bus.mem_addr !== 32'h4 || bus.pc_out !== 32'h0 || bus.if_valid !== 1'b1) begin
      errors++;
      $display("FAIL pre_misaligned got addr %h pc_out %h valid %0b want 4 0 1",
               bus.mem_addr, bus.pc_out, bus.if_valid);
    end
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h102;
    step();
    bus.branch_taken = 1'b0;
    checks++;
    if (bus.misaligned !== 1'b1 || bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h4
        || bus.if_valid !== 1'b0) begin
      errors++;
      $display("FAIL misaligned got flag %0b req %0b addr %h valid %0b want 1 0 4 0",
               bus.misaligned, bus.mem_req, bus.mem_addr, bus.if_valid);
    end
    // An aligned redirect while halted is ignored.
    bus.branch_taken = 1'b1;
    bus.branch_target = 32'h100;
    step();
    step();
    bus.branch_taken = 1'b0;
    checks++;
    if (bus.misaligned !== 1'b1 || bus.mem_req !== 1'b0 || bus.mem_addr !== 32'h4
        || bus.if_valid !== 1'b0) begin
      errors++;
      $display("FAIL halt_branch got flag %0b req %0b addr %h valid %0b want 1 0 4 0",
               bus.misaligned, bus.mem_req, bus.mem_addr, bus.if_valid);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    checks++;
    if (bus.misaligned !== 1'b0 || bus.mem_addr !== 32'h0 || bus.mem_req !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset got flag %0b addr %h req %0b want 0 0 0", bus.misaligned,
               bus.mem_addr, bus.mem_req);
    end
    step();
    checks++;
    if (bus.mem_req !== 1'b1 || bus.mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL halt_restart got req %0b addr %h want 1 0", bus.mem_req, bus.mem_addr);
    end
  endtask

  task automatic test_wrap();
    rst2 = 1'b0;
    checks++;
    if (bus2.mem_addr !== 32'hFFFF_FFFC || bus2.pc_plus4 !== 32'h0) begin
      errors++;
      $display("FAIL wrap_reset got addr %h plus4 %h want fffffffc 0", bus2.mem_addr,
               bus2.pc_plus4);
    end
    step();
    checks++;
    if (bus2.mem_req !== 1'b1 || bus2.mem_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_first got req %0b addr %h want 1 fffffffc", bus2.mem_req,
               bus2.mem_addr);
    end
    step();
    checks++;
    if (bus2.mem_addr !== 32'h0 || bus2.pc_out !== 32'hFFFF_FFFC || bus2.if_valid !== 1'b1
        || bus2.misaligned !== 1'b0) begin
      errors++;
      $display("FAIL wrap_second got addr %h pc_out %h valid %0b flag %0b want 0 fffffffc 1 0",
               bus2.mem_addr, bus2.pc_out, bus2.if_valid, bus2.misaligned);
    end
    step();
    checks++;
    if (bus2.mem_addr !== 32'h4 || bus2.pc_out !== 32'h0) begin
      errors++;
      $display("FAIL wrap_third got addr %h pc_out %h want 4 0", bus2.mem_addr, bus2.pc_out);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst2 = 1'b1;
    bus2.stall = 1'b0;
    bus2.branch_taken = 1'b0;
    bus2.branch_target = 32'h0;
    bus2.mem_ready = 1'b1;
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_mem_wait();
    test_reset_mid();
    test_misaligned();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
